// File: rtl/dffsre_chain.sv
// DEPTH-stage, WIDTH-bit set/clear/enable DFF chain with a per-stage valid bit.
// Optional saturating override counter enabled by defining DFFSRE_CHAIN_OVR_CNT_EN.
module dffsre_chain #(
    parameter int unsigned         WIDTH        = 1,
    parameter int unsigned         DEPTH        = 1,
    parameter bit                  CLK_POLARITY = 1'b1,
    parameter bit                  SET_POLARITY = 1'b1,
    parameter bit                  CLR_POLARITY = 1'b1,
    parameter bit                  EN_POLARITY  = 1'b1,
    parameter logic [WIDTH-1:0]    RST_VALUE    = {WIDTH{1'b0}},
    parameter int unsigned         CNT_WIDTH    = 8
) (
    input  logic             CLK,
    input  logic             SRST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] SET,
    input  logic [WIDTH-1:0] CLR,
    input  logic             VALID_IN,
    output logic [WIDTH-1:0] Q,
    output logic             VALID_OUT
`ifdef DFFSRE_CHAIN_OVR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] OVR_CNT
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dffsre_chain: DEPTH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("dffsre_chain: WIDTH must be >= 1");
    end

    // Single rising-edge flop process; polarity folded into the clock.
    logic clk_act;
    assign clk_act = CLK_POLARITY ? CLK : ~CLK;

    logic             en_act;
    logic [WIDTH-1:0] set_act;
    logic [WIDTH-1:0] clr_act;
    logic [WIDTH-1:0] stage0;

    assign en_act  = (EN == EN_POLARITY);
    assign set_act = SET ^ {WIDTH{~SET_POLARITY}};
    assign clr_act = CLR ^ {WIDTH{~CLR_POLARITY}};
    // Clear beats set, set beats D.
    assign stage0  = (D | set_act) & ~clr_act;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en_act) begin
            data_d[0]  = stage0;
            valid_d[0] = VALID_IN;
            for (int k = 1; k < int'(DEPTH); k++) begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_act) begin
        if (SRST) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                data_q[k] <= RST_VALUE;
            end
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign Q         = data_q[DEPTH-1];
    assign VALID_OUT = valid_q[DEPTH-1];

`ifdef DFFSRE_CHAIN_OVR_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Counts edges where any override is asserted, even if masked by clear.
    always_comb begin
        cnt_d = cnt_q;
        if (en_act && ((|set_act) || (|clr_act)) && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_act) begin
        if (SRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign OVR_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_dffsre_chain.sv
// Bench for dffsre_chain: a rising-edge active-high instance and a falling-edge
// active-low instance share one logical stimulus stream and are checked against queue models.
module tb_dffsre_chain;

    localparam int unsigned DEPTH_A = 3;
    localparam int unsigned DEPTH_B = 4;
    localparam logic [7:0]  RST_A   = 8'h00;
    localparam logic [7:0]  RST_B   = 8'h5A;

    logic       clk = 1'b0;
    logic       srst_s = 1'b0, en_s = 1'b0, vin_s = 1'b0;
    logic [7:0] d_s = '0, set_s = '0, clr_s = '0;

    logic [7:0] q_a, q_b;
    logic       v_a, v_b;
    logic [1:0] cnt_a;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dffsre_chain #(
        .WIDTH(8), .DEPTH(DEPTH_A), .CLK_POLARITY(1'b1), .SET_POLARITY(1'b1),
        .CLR_POLARITY(1'b1), .EN_POLARITY(1'b1), .RST_VALUE(RST_A), .CNT_WIDTH(2)
    ) dut_a (
        .CLK(clk), .SRST(srst_s), .EN(en_s), .D(d_s), .SET(set_s), .CLR(clr_s),
        .VALID_IN(vin_s), .Q(q_a), .VALID_OUT(v_a)
`ifdef DFFSRE_CHAIN_OVR_CNT_EN
        , .OVR_CNT(cnt_a)
`endif
    );

    dffsre_chain #(
        .WIDTH(8), .DEPTH(DEPTH_B), .CLK_POLARITY(1'b0), .SET_POLARITY(1'b0),
        .CLR_POLARITY(1'b0), .EN_POLARITY(1'b0), .RST_VALUE(RST_B), .CNT_WIDTH(8)
    ) dut_b (
        .CLK(clk), .SRST(srst_s), .EN(~en_s), .D(d_s), .SET(~set_s), .CLR(~clr_s),
        .VALID_IN(vin_s), .Q(q_b), .VALID_OUT(v_b)
`ifdef DFFSRE_CHAIN_OVR_CNT_EN
        , .OVR_CNT(cnt_b)
`endif
    );

`ifndef DFFSRE_CHAIN_OVR_CNT_EN
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

    // Reference: queue of what Q will show, oldest first, length DEPTH.
    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int   cnt_m = 0;

    function automatic logic [7:0] override(input logic [7:0] d, input logic [7:0] s,
                                            input logic [7:0] c);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (c[i])      r[i] = 1'b0;
            else if (s[i]) r[i] = 1'b1;
            else           r[i] = d[i];
        end
        return r;
    endfunction

    task automatic model_step(input int which);
        ent_t e;
        ent_t old;
        e.d = override(d_s, set_s, clr_s);
        e.v = vin_s;
        if (which == 0) begin
            if (srst_s) begin
                qa.delete();
                for (int i = 0; i < int'(DEPTH_A); i++) qa.push_back('{RST_A, 1'b0});
                cnt_m = 0;
            end else if (en_s) begin
                qa.push_back(e);
                old = qa.pop_front();
                if ((set_s != 0 || clr_s != 0) && cnt_m < 3) cnt_m++;
            end
        end else begin
            if (srst_s) begin
                qb.delete();
                for (int i = 0; i < int'(DEPTH_B); i++) qb.push_back('{RST_B, 1'b0});
            end else if (en_s) begin
                qb.push_back(e);
                old = qb.pop_front();
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_a();
        check("a_q", {24'h0, q_a}, {24'h0, qa[0].d});
        check("a_valid", {31'h0, v_a}, {31'h0, qa[0].v});
`ifdef DFFSRE_CHAIN_OVR_CNT_EN
        check("a_cnt", {30'h0, cnt_a}, cnt_m);
`endif
    endtask

    task automatic check_b();
        check("b_q", {24'h0, q_b}, {24'h0, qb[0].d});
        check("b_valid", {31'h0, v_b}, {31'h0, qb[0].v});
    endtask

    // Called at posedge+1; covers dut_b's falling edge then dut_a's rising edge.
    task automatic cycle(input logic srst, input logic en, input logic [7:0] d,
                         input logic [7:0] s, input logic [7:0] c, input logic vin);
        srst_s = srst; en_s = en; d_s = d; set_s = s; clr_s = c; vin_s = vin;
        @(negedge clk); #1;
        model_step(1);
        check_b();
        check_a();
        @(posedge clk); #1;
        model_step(0);
        check_a();
        check_b();
    endtask

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic [7:0] s;
        logic [7:0] c;
        logic       vin;
        logic [7:0] exp_q;
        logic       exp_v;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 8'hA5, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b1};
        tbl[3]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 8'hFF, 8'h0F, 8'h03, 1'b1, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'hFC, 1'b1};
        tbl[7]  = '{1'b1, 8'h3C, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 8'hFF, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 8'h11, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0};
        tbl[10] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h3C, 1'b1};
        tbl[12] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        @(posedge clk); #1;
        srst_s = 1'b1; en_s = 1'b0;
        @(negedge clk); #1;
        @(posedge clk); #1;
        model_step(0);
        model_step(1);
        check("rst_a_q", {24'h0, q_a}, {24'h0, RST_A});
        check("rst_a_valid", {31'h0, v_a}, 32'h0);
        check("rst_b_q", {24'h0, q_b}, {24'h0, RST_B});
        check("rst_b_valid", {31'h0, v_b}, 32'h0);
`ifdef DFFSRE_CHAIN_OVR_CNT_EN
        check("rst_a_cnt", {30'h0, cnt_a}, 32'h0);
`endif

        for (int i = 0; i < 13; i++) begin
            cycle(1'b0, tbl[i].en, tbl[i].d, tbl[i].s, tbl[i].c, tbl[i].vin);
            check($sformatf("tbl%0d_q", i), {24'h0, q_a}, {24'h0, tbl[i].exp_q});
            check($sformatf("tbl%0d_valid", i), {31'h0, v_a}, {31'h0, tbl[i].exp_v});
        end

        // Mid-flight reset with EN low on the depth-4 instance.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'($urandom), 8'h00, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b1);
        check("midrst_b_q", {24'h0, q_b}, 32'h5A);
        check("midrst_b_valid", {31'h0, v_b}, 32'h0);
        cycle(1'b0, 1'b1, 8'h77, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
            check("midrst_b_early", {24'h0, q_b}, 32'h5A);
        end
        cycle(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        check("midrst_b_new_q", {24'h0, q_b}, 32'h77);
        check("midrst_b_new_valid", {31'h0, v_b}, 32'h1);

`ifdef DFFSRE_CHAIN_OVR_CNT_EN
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0);
            check($sformatf("cnt_sat%0d", i), {30'h0, cnt_a}, (i + 1 > 3) ? 3 : i + 1);
        end
        cycle(1'b1, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0);
        check("cnt_rst", {30'h0, cnt_a}, 32'h0);
        cycle(1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
        check("cnt_en_low", {30'h0, cnt_a}, 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(15) == 0), 1'($urandom), 8'($urandom),
                  8'($urandom & $urandom & $urandom), 8'($urandom & $urandom & $urandom),
                  1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
